// File: rtl/ob_cmd_mux.sv
// N-channel command front-end for the order book: per-client command FIFOs merged
// round-robin onto one ob port, with responses routed back through an in-order tag FIFO.
package ob_pkg;
  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_BUY       = 3'd1;
  localparam logic [2:0] OP_SELL      = 3'd2;
  localparam logic [2:0] OP_CANCEL    = 3'd3;
  localparam logic [2:0] OP_QRYBIDASK = 3'd4;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [7:0]  uid;
    logic [15:0] price;
    logic [7:0]  qty;
  } cmd_t;

  typedef struct packed {
    logic [7:0]  uid;
    logic [1:0]  status;
    logic [15:0] data;
  } rsp_t;
endpackage

module ob_cmd_mux #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TAG_DEPTH = 16,
  parameter int unsigned CMD_W     = $bits(ob_pkg::cmd_t),
  parameter int unsigned RSP_W     = $bits(ob_pkg::rsp_t)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_CH-1:0]                in_cmd_vld,
  input  logic [N_CH*CMD_W-1:0]          in_cmd,
  output logic [N_CH-1:0]                in_cmd_full_r,
  output logic                           cmd_vld_r,
  output logic [CMD_W-1:0]               cmd_r,
  input  logic                           cmd_full_r,
  input  logic                           rsp_vld,
  input  logic [RSP_W-1:0]               rsp,
  output logic                           rsp_accept,
  output logic [N_CH-1:0]                out_rsp_vld,
  output logic [RSP_W-1:0]               out_rsp,
  input  logic [N_CH-1:0]                out_rsp_accept,
  output logic [$clog2(TAG_DEPTH+1)-1:0] outstanding_r,
  output logic [N_CH-1:0]                err_ovf_r,
  output logic                           err_spur_r
);
  localparam int unsigned CH_W   = $clog2(N_CH);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned TPTR_W = $clog2(TAG_DEPTH);
  localparam int unsigned OUT_W  = $clog2(TAG_DEPTH + 1);

  logic [CMD_W-1:0] mem     [N_CH][DEPTH];
  logic [PTR_W-1:0] rd_ptr  [N_CH];
  logic [PTR_W-1:0] wr_ptr  [N_CH];
  logic [CNT_W-1:0] cnt     [N_CH];
  logic [CNT_W-1:0] cnt_nxt [N_CH];
  logic [N_CH-1:0]  push, pop, nonempty;
  logic [CH_W-1:0]  rr_ptr, grant;
  logic             issue;

  logic [CH_W-1:0]   tag_mem [TAG_DEPTH];
  logic [TPTR_W-1:0] tag_rd, tag_wr;
  logic [CH_W-1:0]   head;
  logic              tag_empty, tag_full, tag_pop;

  // Per-channel push/pop strobes and next occupancy
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      nonempty[i] = (cnt[i] != '0);
      push[i]     = in_cmd_vld[i] & ~in_cmd_full_r[i];
      case ({push[i], pop[i]})
        2'b10:   cnt_nxt[i] = cnt[i] + 1'b1;
        2'b01:   cnt_nxt[i] = cnt[i] - 1'b1;
        default: cnt_nxt[i] = cnt[i];
      endcase
    end
  end

  // Round-robin grant: first non-empty channel at or after rr_ptr
  always_comb begin
    logic            found;
    logic [CH_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    grant = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = CH_W'((32'(rr_ptr) + 32'(k)) % N_CH);
      if (!found && nonempty[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
    issue = (|nonempty) & ~cmd_full_r & ~tag_full;
    pop   = issue ? (N_CH'(1) << grant) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      in_cmd_full_r <= '0;
      err_ovf_r     <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        cnt[i]           <= cnt_nxt[i];
        in_cmd_full_r[i] <= (cnt_nxt[i] == CNT_W'(DEPTH));
        if (in_cmd_vld[i] & in_cmd_full_r[i]) err_ovf_r[i] <= 1'b1;
      end
    end
  end

  // FIFO storage carries no reset; pointers alone define validity
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_cmd[i*CMD_W +: CMD_W];
    end
    if (issue) tag_mem[tag_wr] <= grant;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd_vld_r <= 1'b0;
      cmd_r     <= '0;
      rr_ptr    <= '0;
    end else begin
      cmd_vld_r <= issue;
      if (issue) begin
        cmd_r  <= mem[grant][rd_ptr[grant]];
        rr_ptr <= (grant == CH_W'(N_CH - 1)) ? '0 : grant + 1'b1;
      end
    end
  end

  // Response routing to the channel owning the oldest outstanding command
  always_comb begin
    tag_empty   = (outstanding_r == '0);
    tag_full    = (outstanding_r == OUT_W'(TAG_DEPTH));
    head        = tag_mem[tag_rd];
    rsp_accept  = tag_empty | out_rsp_accept[head];
    tag_pop     = rsp_vld & rsp_accept & ~tag_empty;
    out_rsp_vld = (rsp_vld & ~tag_empty) ? (N_CH'(1) << head) : '0;
    out_rsp     = rsp;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_rd        <= '0;
      tag_wr        <= '0;
      outstanding_r <= '0;
      err_spur_r    <= 1'b0;
    end else begin
      if (issue)   tag_wr <= tag_wr + 1'b1;
      if (tag_pop) tag_rd <= tag_rd + 1'b1;
      case ({issue, tag_pop})
        2'b10:   outstanding_r <= outstanding_r + 1'b1;
        2'b01:   outstanding_r <= outstanding_r - 1'b1;
        default: outstanding_r <= outstanding_r;
      endcase
      if (rsp_vld & tag_empty) err_spur_r <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ob_cmd_mux.sv
// Bench for ob_cmd_mux: directed scenarios plus random traffic, all checked each cycle
// against a queue-based model of the channel FIFOs, round-robin arbiter and tag order.
module tb_ob_cmd_mux;
  import ob_pkg::*;

  localparam int unsigned N_CH      = 4;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned TAG_DEPTH = 16;
  localparam int unsigned CMD_W     = $bits(cmd_t);
  localparam int unsigned RSP_W     = $bits(rsp_t);
  localparam int unsigned OUT_W     = $clog2(TAG_DEPTH + 1);

  typedef logic [CMD_W-1:0] cmd_w_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_CH-1:0]        in_cmd_vld;
  logic [N_CH*CMD_W-1:0]  in_cmd;
  logic [N_CH-1:0]        in_cmd_full_r;
  logic                   cmd_vld_r;
  logic [CMD_W-1:0]       cmd_r;
  logic                   cmd_full_r;
  logic                   rsp_vld;
  logic [RSP_W-1:0]       rsp;
  logic                   rsp_accept;
  logic [N_CH-1:0]        out_rsp_vld;
  logic [RSP_W-1:0]       out_rsp;
  logic [N_CH-1:0]        out_rsp_accept;
  logic [OUT_W-1:0]       outstanding_r;
  logic [N_CH-1:0]        err_ovf_r;
  logic                   err_spur_r;

  always #5 clk = ~clk;

  ob_cmd_mux #(.N_CH(N_CH), .DEPTH(DEPTH), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_cmd_vld(in_cmd_vld), .in_cmd(in_cmd), .in_cmd_full_r(in_cmd_full_r),
    .cmd_vld_r(cmd_vld_r), .cmd_r(cmd_r), .cmd_full_r(cmd_full_r),
    .rsp_vld(rsp_vld), .rsp(rsp), .rsp_accept(rsp_accept),
    .out_rsp_vld(out_rsp_vld), .out_rsp(out_rsp), .out_rsp_accept(out_rsp_accept),
    .outstanding_r(outstanding_r), .err_ovf_r(err_ovf_r), .err_spur_r(err_spur_r)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  cmd_w_t          q [N_CH][$];
  int              tagq [$];
  int              rr;
  logic            m_vld;
  cmd_w_t          m_cmd;
  logic [N_CH-1:0] m_ovf;
  logic            m_spur;

  function automatic void model_reset();
    for (int c = 0; c < N_CH; c++) q[c].delete();
    tagq.delete();
    rr     = 0;
    m_vld  = 1'b0;
    m_cmd  = '0;
    m_ovf  = '0;
    m_spur = 1'b0;
  endfunction

  // Compare all outputs against the model, advance the model, then cross one clock edge
  task automatic step();
    logic [N_CH-1:0] exp_full;
    logic [N_CH-1:0] exp_orv;
    logic [N_CH-1:0] full_pre;
    logic            exp_acc;
    bit              can_issue;
    bit              found;
    int              g;
    #1;
    for (int c = 0; c < N_CH; c++) exp_full[c] = (q[c].size() == DEPTH);
    check("cmd_vld_r", 64'(cmd_vld_r), 64'(m_vld));
    check("cmd_r", 64'(cmd_r), 64'(m_cmd));
    check("outstanding_r", 64'(outstanding_r), 64'(tagq.size()));
    check("in_cmd_full_r", 64'(in_cmd_full_r), 64'(exp_full));
    check("err_ovf_r", 64'(err_ovf_r), 64'(m_ovf));
    check("err_spur_r", 64'(err_spur_r), 64'(m_spur));
    exp_acc = (tagq.size() == 0) ? 1'b1 : out_rsp_accept[tagq[0]];
    exp_orv = (rsp_vld && tagq.size() > 0) ? N_CH'(1 << tagq[0]) : '0;
    check("rsp_accept", 64'(rsp_accept), 64'(exp_acc));
    check("out_rsp_vld", 64'(out_rsp_vld), 64'(exp_orv));
    check("out_rsp", 64'(out_rsp), 64'(rsp));

    if (!rst) begin
      model_reset();
    end else begin
      can_issue = 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        full_pre[c] = (q[c].size() == DEPTH);
        if (q[c].size() > 0) can_issue = 1'b1;
      end
      can_issue = can_issue && !cmd_full_r && (tagq.size() < TAG_DEPTH);
      if (rsp_vld) begin
        if (tagq.size() == 0) m_spur = 1'b1;
        else if (out_rsp_accept[tagq[0]]) void'(tagq.pop_front());
      end
      m_vld = 1'b0;
      if (can_issue) begin
        found = 1'b0;
        g = 0;
        for (int k = 0; k < N_CH; k++) begin
          if (!found && q[(rr + k) % N_CH].size() > 0) begin
            g = (rr + k) % N_CH;
            found = 1'b1;
          end
        end
        m_cmd = q[g].pop_front();
        m_vld = 1'b1;
        tagq.push_back(g);
        rr = (g + 1) % N_CH;
      end
      for (int c = 0; c < N_CH; c++) begin
        if (in_cmd_vld[c]) begin
          if (full_pre[c]) m_ovf[c] = 1'b1;
          else q[c].push_back(in_cmd[c*CMD_W +: CMD_W]);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rst            = 1'b1;
    in_cmd_vld     = '0;
    in_cmd         = '0;
    cmd_full_r     = 1'b0;
    rsp_vld        = 1'b0;
    rsp            = '0;
    out_rsp_accept = '1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  function automatic cmd_w_t mk(input logic [2:0] op, input int uid);
    cmd_t c;
    c.opcode = op;
    c.uid    = 8'(uid);
    c.price  = 16'($urandom);
    c.qty    = 8'($urandom);
    return c;
  endfunction

  task automatic set_cmd(input int ch, input cmd_w_t c);
    in_cmd_vld[ch] = 1'b1;
    in_cmd[ch*CMD_W +: CMD_W] = c;
  endtask

  cmd_t cc;
  rsp_t rr_rsp;
  int   n_drain;

  initial begin
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    check("rst_cmd_vld", 64'(cmd_vld_r), 64'd0);
    check("rst_cmd", 64'(cmd_r), 64'd0);
    check("rst_outstanding", 64'(outstanding_r), 64'd0);
    check("rst_full", 64'(in_cmd_full_r), 64'd0);
    rst = 1'b1;

    // Single command latency and response routing
    set_cmd(2, mk(OP_QRYBIDASK, 'h10));
    step();
    idle();
    check("lat_t1_vld", 64'(cmd_vld_r), 64'd0);
    step();
    cc = cmd_r;
    check("lat_t2_vld", 64'(cmd_vld_r), 64'd1);
    check("lat_uid", 64'(cc.uid), 64'h10);
    check("lat_op", 64'(cc.opcode), 64'(OP_QRYBIDASK));
    check("out_one", 64'(outstanding_r), 64'd1);
    rr_rsp = '0;
    rr_rsp.uid = 8'h10;
    rsp_vld = 1'b1;
    rsp = rr_rsp;
    #1;
    check("rsp_route_ch2", 64'(out_rsp_vld), 64'b0100);
    step();
    idle();
    check("out_zero", 64'(outstanding_r), 64'd0);

    // Round-robin fairness across preloaded channels
    do_reset();
    cmd_full_r = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) set_cmd(c, mk(OP_BUY, c * 16 + k));
      step();
    end
    in_cmd_vld = '0;
    cmd_full_r = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      cc = cmd_r;
      check("rr_vld", 64'(cmd_vld_r), 64'd1);
      check("rr_ch", 64'(cc.uid >> 4), 64'(i % 4));
      check("rr_seq", 64'(cc.uid[3:0]), 64'(i / 4));
    end
    rsp_vld = 1'b1;
    repeat (8) step();
    idle();
    check("rr_drained", 64'(outstanding_r), 64'd0);

    // Backpressure hold and in-order release
    do_reset();
    cmd_full_r = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_cmd_vld = '0;
      set_cmd(1, mk(OP_SELL, 'h20 + k));
      step();
    end
    in_cmd_vld = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_hold", 64'(cmd_vld_r), 64'd0);
    end
    cmd_full_r = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      cc = cmd_r;
      check("bp_rel_vld", 64'(cmd_vld_r), 64'd1);
      check("bp_rel_uid", 64'(cc.uid), 64'('h20 + k));
    end
    rsp_vld = 1'b1;
    repeat (3) step();
    idle();

    // FIFO full and overflow drop
    do_reset();
    cmd_full_r = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_cmd_vld = '0;
      set_cmd(0, mk(OP_BUY, 'h30 + k));
      step();
      if (k == 3) check("full_after4", 64'(in_cmd_full_r[0]), 64'd1);
    end
    check("ovf_flag", 64'(err_ovf_r), 64'b0001);
    in_cmd_vld = '0;
    cmd_full_r = 1'b0;
    n_drain = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (cmd_vld_r) n_drain++;
    end
    check("drain_cnt", 64'(n_drain), 64'd4);
    rsp_vld = 1'b1;
    repeat (4) step();
    idle();

    // Response stall on head channel, then routing to next tag
    do_reset();
    set_cmd(3, mk(OP_CANCEL, 'h40));
    step();
    in_cmd_vld = '0;
    set_cmd(1, mk(OP_CANCEL, 'h41));
    step();
    in_cmd_vld = '0;
    step();
    check("stall_out2", 64'(outstanding_r), 64'd2);
    rsp_vld = 1'b1;
    out_rsp_accept = 4'b0111;
    #1;
    check("stall_acc", 64'(rsp_accept), 64'd0);
    check("stall_vld", 64'(out_rsp_vld), 64'b1000);
    step();
    check("stall_held", 64'(outstanding_r), 64'd2);
    out_rsp_accept = '1;
    step();
    check("stall_pop", 64'(outstanding_r), 64'd1);
    #1;
    check("next_route", 64'(out_rsp_vld), 64'b0010);
    step();
    idle();

    // Tag limit stall, then spurious response after reset
    do_reset();
    cmd_full_r = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) set_cmd(c, mk(OP_BUY, c * 16 + k));
      step();
    end
    in_cmd_vld = '0;
    cmd_full_r = 1'b0;
    repeat (16) step();
    check("tag_full", 64'(outstanding_r), 64'd16);
    set_cmd(0, mk(OP_SELL, 'h55));
    step();
    in_cmd_vld = '0;
    repeat (3) step();
    check("tag_stall", 64'(cmd_vld_r), 64'd0);
    check("tag_still16", 64'(outstanding_r), 64'd16);
    do_reset();
    rsp_vld = 1'b1;
    #1;
    check("spur_acc", 64'(rsp_accept), 64'd1);
    check("spur_vld", 64'(out_rsp_vld), 64'd0);
    step();
    idle();
    check("spur_flag", 64'(err_spur_r), 64'd1);

    // Random traffic with occasional reset
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) != 0);
      for (int c = 0; c < N_CH; c++) begin
        in_cmd_vld[c] = ($urandom_range(0, 1) == 1);
        in_cmd[c*CMD_W +: CMD_W] = CMD_W'({$urandom(), $urandom()});
        out_rsp_accept[c] = ($urandom_range(0, 3) != 0);
      end
      cmd_full_r = ($urandom_range(0, 3) == 0);
      rsp_vld    = ($urandom_range(0, 1) == 1);
      rsp        = RSP_W'($urandom());
      step();
    end
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ob_cmd_mux.md
Name: ob_cmd_mux

Overview:
- Parametrised N-channel front-end for the order book (ob) command/response interface.
- Each of N_CH clients gets its own command FIFO. Commands are merged round-robin onto the single ob command port.
- Each ob response is routed back to the client that issued the matching command, using an in-order tag FIFO.
- Sits between client agents (or the tb harness) and ob. The ob itself is unchanged.

Parameters:
- N_CH, 4: number of client channels (2..8).
- DEPTH, 4: per-channel command FIFO depth (power of 2, ≥2).
- TAG_DEPTH, 16: maximum commands outstanding in ob awaiting a response (power of 2).
- CMD_W, $bits(ob_pkg::cmd_t): command word width.
- RSP_W, $bits(ob_pkg::rsp_t): response word width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-low.
- in_cmd_vld  in  N_CH  per-channel command push strobe.
- in_cmd  in  N_CH*CMD_W  per-channel command; channel i at [i*CMD_W +: CMD_W].
- in_cmd_full_r  out  N_CH  registered per-channel FIFO full.
- cmd_vld_r  out  1  registered command valid to ob.
- cmd_r  out  CMD_W  registered command to ob.
- cmd_full_r  in  1  ob command backpressure (registered in ob).
- rsp_vld  in  1  ob response valid.
- rsp  in  RSP_W  ob response.
- rsp_accept  out  1  response accept to ob (combinational).
- out_rsp_vld  out  N_CH  one-hot response valid to the owning channel.
- out_rsp  out  RSP_W  response data, broadcast to all channels.
- out_rsp_accept  in  N_CH  per-channel response accept.
- outstanding_r  out  $clog2(TAG_DEPTH+1)  commands issued and not yet answered.
- err_ovf_r  out  N_CH  sticky: push while in_cmd_full_r[i].
- err_spur_r  out  1  sticky: rsp_vld with tag FIFO empty.

Behaviour:
Reset:
- Reset is synchronous and active-low.
- On reset: all FIFOs empty, in_cmd_full_r=0, cmd_vld_r=0, cmd_r=0, round-robin pointer=0, outstanding_r=0, err_*=0.
- Reset mid-operation discards all queued commands and tags. Subsequent ob responses to pre-reset commands count as spurious.

Push:
- Channel i push is accepted when in_cmd_vld[i] & !in_cmd_full_r[i].
- in_cmd_full_r[i] is registered and equals (next occupancy == DEPTH). There is no skid and no overflow.
- A push while in_cmd_full_r[i] is high is dropped and sets err_ovf_r[i].
- The FIFO is unchanged by a dropped push.
- Simultaneous push and pop on the same channel is legal; occupancy is unchanged.

Issue:
- Issue condition: any FIFO non-empty & !cmd_full_r & tag FIFO not full.
- The grant goes to the first non-empty channel at or after the round-robin pointer, wrapping modulo N_CH.
- The granted FIFO head is popped.
- cmd_vld_r/cmd_r load on the next edge; otherwise cmd_vld_r=0 and cmd_r holds its value.
- The channel index is pushed into the tag FIFO. The pointer becomes grant+1, wrapping modulo N_CH.
- The pointer is unchanged when there is no grant.
- Latency: a push sampled at edge t gives cmd_vld_r high after edge t+1 at the earliest (2 cycles).
- cmd_vld_r is single-cycle per command.
- Back-to-back issue is allowed every cycle while the issue condition holds.

Response:
- ob returns exactly one response per command, in order. Head tag h = channel of the oldest outstanding command.
- out_rsp = rsp.
- out_rsp_vld = rsp_vld & tag non-empty ? onehot(h) : 0.
- rsp_accept = tag non-empty ? out_rsp_accept[h] : 1.
- The tag pops when rsp_vld & rsp_accept & tag non-empty. This path is combinational, with zero latency.
- rsp_vld with the tag FIFO empty sets err_spur_r. The response is accepted and dropped.

outstanding_r:
- +1 on issue, −1 on tag pop, net 0 when both happen in the same cycle.
- Equals tag FIFO occupancy.
- When outstanding_r == TAG_DEPTH, issue stalls and FIFOs keep filling.

Test Plan:
- Reset & single command: release rst, push ch2 opcode QRYBIDASK uid=0x10 → cmd_vld_r high exactly 2 cycles after push with uid 0x10. Then rsp_vld uid=0x10 with out_rsp_accept=all 1s → out_rsp_vld=0b0100, outstanding_r 1→0.
- Round-robin fairness: preload 2 commands in each of ch0..ch3, cmd_full_r=0 → issue order is ch0,ch1,ch2,ch3,ch0,ch1,ch2,ch3 on 8 consecutive cycles.
- Backpressure: hold cmd_full_r=1 for 5 cycles with ch1 holding 3 commands → no cmd_vld_r. On release, the 3 commands issue on consecutive cycles in FIFO order.
- FIFO full/overflow: push 5 commands to ch0 (DEPTH=4) with cmd_full_r=1 → in_cmd_full_r[0] high after the 4th push. The 5th push is dropped and err_ovf_r=0b0001. Draining yields exactly 4 commands.
- Response stall: out_rsp_accept[3]=0 while the head tag is ch3 → rsp_accept=0 and the tag is held. Set accept=1 → pop, and the next response routes to the next tagged channel.
- Tag limit & spurious response: issue 16 commands with no response → outstanding_r=16 and the 17th stalls. Then rsp_vld with the tag FIFO empty after reset → err_spur_r=1 and rsp_accept=1.
